// File: rtl/mpu_pkg.sv
// Shared MPU constants and types used by the streaming matrix blocks.
package mpu_pkg;

    localparam int MPU_DIM    = 5;
    localparam int MPU_ELEM_W = 8;
    localparam int MPU_ELEMS  = MPU_DIM * MPU_DIM;

    typedef logic signed [MPU_ELEM_W-1:0] mpu_elem_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } mpu_state_e;

endpackage

// File: rtl/mpu_rc_counter.sv
// Two-level index counter: the fast index steps every enable, the slow index
// steps when the fast one wraps; last marks the final (DIM-1, DIM-1) position.
module mpu_rc_counter #(
    parameter int DIM   = 5,
    parameter int IDX_W = $clog2(DIM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [IDX_W-1:0] fast,
    output logic [IDX_W-1:0] slow,
    output logic             last
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIM - 1);

    logic [IDX_W-1:0] fast_q, fast_d;
    logic [IDX_W-1:0] slow_q, slow_d;

    always_comb begin
        fast_d = fast_q;
        slow_d = slow_q;
        if (clr) begin
            fast_d = '0;
            slow_d = '0;
        end else if (en) begin
            if (fast_q == IDX_MAX) begin
                fast_d = '0;
                slow_d = (slow_q == IDX_MAX) ? '0 : slow_q + 1'b1;
            end else begin
                fast_d = fast_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fast_q <= '0;
            slow_q <= '0;
        end else begin
            fast_q <= fast_d;
            slow_q <= slow_d;
        end
    end

    assign fast = fast_q;
    assign slow = slow_q;
    assign last = (fast_q == IDX_MAX) && (slow_q == IDX_MAX);

endmodule

// File: rtl/mpu_stream_transpose.sv
// Streaming 5x5 transpose: buffers a row-major matrix, then replays it
// column-major. Input and output phases never overlap.
module mpu_stream_transpose
    import mpu_pkg::*;
#(
    parameter int DATA_W = MPU_ELEM_W,
    parameter int DIM    = MPU_DIM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              err
);

    localparam int ELEMS  = DIM * DIM;
    localparam int IDX_W  = $clog2(DIM);
    localparam int ADDR_W = $clog2(ELEMS);

    mpu_state_e state_q, state_d;
    logic       err_q, err_d;
    logic [DATA_W-1:0] buf_q [ELEMS];
    logic [DATA_W-1:0] buf_d [ELEMS];

    logic [IDX_W-1:0]  wr_col, wr_row, rd_row, rd_col;
    logic              wr_last, rd_last;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              in_fire, out_fire;

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == DRAIN);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Write walks col fastest, read walks row fastest; both address row*DIM+col.
    mpu_rc_counter #(.DIM(DIM), .IDX_W(IDX_W)) u_wr_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (in_fire),
        .clr  (state_q == DRAIN),
        .fast (wr_col),
        .slow (wr_row),
        .last (wr_last)
    );

    mpu_rc_counter #(.DIM(DIM), .IDX_W(IDX_W)) u_rd_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (out_fire),
        .clr  (state_q == FILL),
        .fast (rd_row),
        .slow (rd_col),
        .last (rd_last)
    );

    assign wr_addr = ADDR_W'(wr_row) * ADDR_W'(DIM) + ADDR_W'(wr_col);
    assign rd_addr = ADDR_W'(rd_row) * ADDR_W'(DIM) + ADDR_W'(rd_col);

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        buf_d   = buf_q;
        case (state_q)
            FILL: begin
                if (in_fire) begin
                    buf_d[wr_addr] = in_data;
                    err_d          = (in_last != wr_last);
                    if (wr_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && rd_last) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign out_data = (state_q == DRAIN) ? buf_q[rd_addr] : '0;
    assign out_last = (state_q == DRAIN) && rd_last;
    assign err      = err_q;

endmodule

// File: tb/tb_mpu_stream_transpose.sv
// Directed bench for mpu_stream_transpose: ordering, signedness, backpressure,
// framing errors, mid-drain reset and back-to-back frames.
module tb_mpu_stream_transpose;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       err;

    mpu_stream_transpose dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .err      (err)
    );

    always #5 clk = ~clk;

    int         n_chk;
    int         n_pass;
    int         err_cnt;
    int         first_out_cyc [2];
    int         last_in_cyc   [2];
    logic [7:0] in_vals  [50];
    logic       in_lasts [50];
    logic [7:0] got      [50];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load(input int base);
        for (int i = 0; i < 50; i++) begin
            in_vals[i]  = 8'(base + i);
            in_lasts[i] = (i % 25 == 24);
        end
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready 1,0,0 repeating in drain.
    task automatic run(input int nframes, input int mode, input int stop_at);
        int         ii;
        int         oi;
        int         cyc;
        int         dcnt;
        int         f;
        int         j;
        logic       err_exp;
        logic       prev_stall;
        logic       prev_valid;
        logic [7:0] prev_data;
        logic [7:0] e;
        ii = 0; oi = 0; cyc = 0; dcnt = 0;
        err_exp = 1'b0; prev_stall = 1'b0; prev_valid = 1'b0; prev_data = '0;
        err_cnt = 0;
        forever begin
            @(negedge clk);
            in_valid  = (ii < 25 * nframes);
            in_data   = in_valid ? in_vals[ii] : 8'h00;
            in_last   = in_valid ? in_lasts[ii] : 1'b0;
            out_ready = (mode == 0) ? 1'b1 : (dcnt % 3 == 0);
            chk("err", {31'd0, err}, {31'd0, err_exp});
            if (err) err_cnt++;
            err_exp = 1'b0;
            chk("ready_excl", {31'd0, in_ready}, {31'd0, !out_valid});
            if (prev_stall) chk("hold", {24'd0, out_data}, {24'd0, prev_data});
            if (in_valid && in_ready) begin
                err_exp = (in_last != (ii % 25 == 24));
                if (ii % 25 == 24) last_in_cyc[ii / 25] = cyc;
                ii++;
            end
            if (out_valid && !prev_valid) first_out_cyc[oi / 25] = cyc;
            if (out_valid && out_ready) begin
                f = oi / 25;
                j = oi % 25;
                e = in_vals[f * 25 + (j % 5) * 5 + j / 5];
                chk("data", {24'd0, out_data}, {24'd0, e});
                chk("last", {31'd0, out_last}, {31'd0, (j == 24)});
                got[oi] = out_data;
                oi++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_valid = out_valid;
            if (out_valid) dcnt++; else dcnt = 0;
            cyc++;
            @(posedge clk);
            if (oi == 25 * nframes || (stop_at > 0 && oi == stop_at)) break;
            if (cyc > 400) begin
                chk("timeout", 32'd0, 32'd1);
                break;
            end
        end
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        clk = 1'b0; rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential values 0..24
        load(0);
        run(1, 0, 0);
        chk("seq_latency", first_out_cyc[0], last_in_cyc[0] + 1);
        chk("seq_o0", {24'd0, got[0]}, 32'd0);
        chk("seq_o1", {24'd0, got[1]}, 32'd5);
        chk("seq_o4", {24'd0, got[4]}, 32'd20);
        chk("seq_o5", {24'd0, got[5]}, 32'd1);
        chk("seq_o23", {24'd0, got[23]}, 32'd19);
        chk("seq_o24", {24'd0, got[24]}, 32'd24);

        // Signed extremes
        for (int i = 0; i < 50; i++) begin
            in_vals[i]  = 8'h00;
            in_lasts[i] = (i % 25 == 24);
        end
        in_vals[3]  = 8'h80;
        in_vals[21] = 8'h7f;
        run(1, 0, 0);
        chk("sign_m128", {24'd0, got[15]}, 32'h80);
        chk("sign_p127", {24'd0, got[9]}, 32'h7f);
        chk("sign_zero", {24'd0, got[10]}, 32'h00);

        // Backpressure during drain
        load(40);
        run(1, 1, 0);
        chk("bp_o1", {24'd0, got[1]}, 32'd45);
        chk("bp_o24", {24'd0, got[24]}, 32'd64);

        // Framing mismatch: in_last on beat 10, missing on beat 24
        load(200);
        in_lasts[10] = 1'b1;
        in_lasts[24] = 1'b0;
        run(1, 0, 0);
        chk("frame_err_cnt", err_cnt, 32'd2);
        chk("frame_o2", {24'd0, got[2]}, 32'd210);

        // Reset while output beat 7 is presented
        load(0);
        run(1, 0, 7);
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_data", {24'd0, out_data}, 32'd11);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_data", {24'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load(100);
        run(1, 0, 0);
        chk("post_rst_o0", {24'd0, got[0]}, 32'd100);
        chk("post_rst_o1", {24'd0, got[1]}, 32'd105);

        // Two back-to-back frames with in_valid held high
        load(30);
        run(2, 0, 0);
        chk("b2b_lat0", first_out_cyc[0], last_in_cyc[0] + 1);
        chk("b2b_lat1", first_out_cyc[1], last_in_cyc[1] + 1);
        chk("b2b_period", first_out_cyc[1] - first_out_cyc[0], 32'd50);
        chk("b2b_f2_o0", {24'd0, got[25]}, 32'd55);
        chk("b2b_f2_o49", {24'd0, got[49]}, 32'd79);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
